inst_fetch_stage: RTL and testbench

Instruction fetch stage sitting directly upstream of the instruction field splitter. Holds the program counter, drives the instruction-memory address and captures the returned word into an IF/ID register whose instruction output feeds the splitter's ins_in. Supports pipeline stall, branch/jump redirect with flush, and a fetch counter for debug.

---
 rtl/inst_fetch_stage.sv | 84 ++++++++
 tb/tb_inst_fetch_stage.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/inst_fetch_stage.sv
// Instruction fetch stage: program counter, instruction-memory addressing and
// the IF/ID register feeding the field splitter, with stall, redirect/flush and a fetch counter.
module inst_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ins_out,
  output logic [31:0] pc_out,
  output logic [31:0] pc4_out,
  output logic        valid_out,
  output logic [31:0] fetch_count
);

  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;
  localparam logic [31:0] PC_STEP   = 32'h0000_0004;
  localparam logic [31:0] CNT_STEP  = 32'h0000_0001;

  logic [31:0] pc_r,     pc_next_s;
  logic [31:0] ins_r,    ins_next_s;
  logic [31:0] pc_out_r, pc_out_next_s;
  logic [31:0] pc4_r,    pc4_next_s;
  logic [31:0] count_r,  count_next_s;
  logic        valid_r,  valid_next_s;

  // Next-state selection: redirect beats stall, stall beats normal advance.
  always_comb begin
    pc_next_s     = pc_r;
    ins_next_s    = ins_r;
    pc_out_next_s = pc_out_r;
    pc4_next_s    = pc4_r;
    count_next_s  = count_r;
    valid_next_s  = valid_r;
    if (redirect_valid) begin
      // Flush the slot but keep pc_out/pc4_out: they still describe the last real fetch.
      pc_next_s    = redirect_pc & WORD_MASK;
      ins_next_s   = NOP_WORD;
      valid_next_s = 1'b0;
    end else if (!stall) begin
      ins_next_s    = imem_rdata;
      pc_out_next_s = pc_r;
      pc4_next_s    = pc_r + PC_STEP;
      valid_next_s  = 1'b1;
      pc_next_s     = pc_r + PC_STEP;
      count_next_s  = count_r + CNT_STEP;
    end else begin
      pc_next_s     = pc_r;
      ins_next_s    = ins_r;
    end
  end

  // State registers with synchronous reset overriding every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r     <= RESET_PC & WORD_MASK;
      ins_r    <= NOP_WORD;
      pc_out_r <= 32'h0000_0000;
      pc4_r    <= 32'h0000_0000;
      valid_r  <= 1'b0;
      count_r  <= 32'h0000_0000;
    end else begin
      pc_r     <= pc_next_s;
      ins_r    <= ins_next_s;
      pc_out_r <= pc_out_next_s;
      pc4_r    <= pc4_next_s;
      valid_r  <= valid_next_s;
      count_r  <= count_next_s;
    end
  end

  assign imem_addr   = pc_r & WORD_MASK;
  assign ins_out     = ins_r;
  assign pc_out      = pc_out_r;
  assign pc4_out     = pc4_r;
  assign valid_out   = valid_r;
  assign fetch_count = count_r;

endmodule

// File: tb/tb_inst_fetch_stage.sv
// Self-checking bench for inst_fetch_stage: per-cycle model comparison plus
// hand-computed checkpoints from the directed scenarios.
module tb_inst_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0000_0000;
  logic [31:0] imem_addr, imem_rdata, ins_out, pc_out, pc4_out, fetch_count;
  logic        valid_out;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Model: fetch address, address of the word held in IF/ID, whether it is real,
  // whether anything was fetched since reset, and the fetch count.
  logic [31:0] m_pc, m_pcout, m_cnt;
  bit          m_valid, m_any;

  inst_fetch_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .ins_out(ins_out), .pc_out(pc_out), .pc4_out(pc4_out),
    .valid_out(valid_out), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  // ROM contents: word 0 is a distinctive instruction, word i otherwise 0x1000_0000+i.
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    if (a == 32'h0000_0000) return 32'h2008_0005;
    return 32'h1000_0000 + (a >> 2);
  endfunction

  assign imem_rdata = rom_word(imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock edge with the given inputs; the model advances by the same rules.
  task automatic step(input logic r, input logic s, input logic rv, input logic [31:0] rpc);
    rst = r; stall = s; redirect_valid = rv; redirect_pc = rpc;
    @(posedge clk);
    if (r) begin
      m_pc = 32'h0000_0000; m_pcout = 32'h0000_0000; m_cnt = 32'h0000_0000;
      m_valid = 1'b0; m_any = 1'b0;
    end else if (rv) begin
      m_pc = {rpc[31:2], 2'b00};
      m_valid = 1'b0;
    end else if (!s) begin
      m_pcout = m_pc;
      m_pc = m_pc + 32'd4;
      m_cnt = m_cnt + 32'd1;
      m_valid = 1'b1;
      m_any = 1'b1;
    end
    chk_en = 1'b1;
    @(negedge clk);
  endtask

  // Every cycle: the IF/ID word is the ROM word at pc_out when valid, else a NOP.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("imem_addr", imem_addr, {m_pc[31:2], 2'b00});
      chk("ins_out", ins_out, m_valid ? rom_word(m_pcout) : NOP);
      chk("pc_out", pc_out, m_pcout);
      chk("pc4_out", pc4_out, m_any ? m_pcout + 32'd4 : 32'h0000_0000);
      chk("valid_out", {31'd0, valid_out}, {31'd0, m_valid});
      chk("fetch_count", fetch_count, m_cnt);
    end
  end

  initial begin
    // Reset held with stall and redirect asserted.
    repeat (3) step(1'b1, 1'b1, 1'b1, 32'h0000_0123);
    chk("rst_addr", imem_addr, 32'h0000_0000);
    chk("rst_ins", ins_out, 32'h0000_0000);
    chk("rst_valid", {31'd0, valid_out}, 32'd0);
    chk("rst_cnt", fetch_count, 32'd0);

    // First fetch after reset.
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("first_ins", ins_out, 32'h2008_0005);
    chk("first_pc", pc_out, 32'h0000_0000);
    chk("first_pc4", pc4_out, 32'h0000_0004);
    chk("first_valid", {31'd0, valid_out}, 32'd1);

    // Advance to pc=0x8, then stall two cycles.
    step(1'b0, 1'b0, 1'b0, 32'h0);
    repeat (2) step(1'b0, 1'b1, 1'b0, 32'h0);
    chk("stall_addr", imem_addr, 32'h0000_0008);
    chk("stall_ins", ins_out, 32'h1000_0001);
    chk("stall_pc", pc_out, 32'h0000_0004);
    chk("stall_cnt", fetch_count, 32'd2);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("unstall_ins", ins_out, 32'h1000_0002);

    // Complete five sequential fetches.
    repeat (2) step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("seq_ins", ins_out, 32'h1000_0004);
    chk("seq_pc", pc_out, 32'h0000_0010);
    chk("seq_cnt", fetch_count, 32'd5);

    // Redirect with stall; misaligned target.
    step(1'b0, 1'b1, 1'b1, 32'h0000_0043);
    chk("redir_addr", imem_addr, 32'h0000_0040);
    chk("redir_ins", ins_out, 32'h0000_0000);
    chk("redir_valid", {31'd0, valid_out}, 32'd0);
    chk("redir_cnt", fetch_count, 32'd5);
    chk("redir_pc_hold", pc_out, 32'h0000_0010);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("target_ins", ins_out, 32'h1000_0010);
    chk("target_pc", pc_out, 32'h0000_0040);

    // Redirect followed by a stall keeps the bubble.
    step(1'b0, 1'b0, 1'b1, 32'h0000_0100);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    chk("bubble_hold", {31'd0, valid_out}, 32'd0);

    // Address wrap at the top of memory.
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("wrap_pc", pc_out, 32'hFFFF_FFFC);
    chk("wrap_pc4", pc4_out, 32'h0000_0000);
    chk("wrap_ins", ins_out, 32'h4FFF_FFFF);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("wrap_pc_next", pc_out, 32'h0000_0000);
    chk("wrap_cnt", fetch_count, 32'd8);

    // Reset mid-run discards everything.
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("mid_rst_ins", ins_out, 32'h0000_0000);
    chk("mid_rst_pc4", pc4_out, 32'h0000_0000);
    chk("mid_rst_cnt", fetch_count, 32'd0);
    chk("mid_rst_addr", imem_addr, 32'h0000_0000);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("post_rst_ins", ins_out, 32'h2008_0005);
    chk("post_rst_cnt", fetch_count, 32'd1);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
